// File: rtl/evm_ballot_unit.sv
// evm_ballot_unit: voter-side ballot unit for the voting machine counter.
// Ports: clk, rst (async active-low); poll_open, ballot_issue, btn[4:0] in;
//        vo_en, vo_switch[4:0], ready_led, busy, beep, timed_out,
//        multi_press, cast_count[7:0] out (all registered).
module evm_ballot_unit #(
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BEEP_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_open,
    input  logic       ballot_issue,
    input  logic [4:0] btn,
    output logic       vo_en,
    output logic [4:0] vo_switch,
    output logic       ready_led,
    output logic       busy,
    output logic       beep,
    output logic       timed_out,
    output logic       multi_press,
    output logic [7:0] cast_count
);

    localparam int DW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_DEBOUNCE = 3'd2;
    localparam logic [2:0] S_CAST     = 3'd3;
    localparam logic [2:0] S_BEEP     = 3'd4;
    localparam logic [2:0] S_RELEASE  = 3'd5;

    logic [4:0]    sync1_q;
    logic [4:0]    btn_s_q;
    logic [2:0]    state_q, state_d;
    logic [4:0]    cand_q, cand_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          to_pulse;
    logic          mp_pulse;
    logic          multi;
    logic          one_hot;

    logic          vo_en_q;
    logic [4:0]    vo_switch_q;
    logic          ready_q;
    logic          busy_q;
    logic          beep_q;
    logic          timed_out_q;
    logic          multi_q;
    logic [7:0]    cast_count_q;

    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign multi   = |(btn_s_q & (btn_s_q - 5'd1));
    assign one_hot = (btn_s_q != 5'd0) && !multi;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        timer_d  = timer_q;
        deb_d    = deb_q;
        bcnt_d   = bcnt_q;
        to_pulse = 1'b0;
        mp_pulse = 1'b0;
        // Closing the poll aborts any ballot in progress; a cast already
        // in its CAST cycle has been issued, so nothing is lost there.
        if (!poll_open && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cand_d  = 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ballot_issue && poll_open) begin
                        state_d = S_ARMED;
                        timer_d = TW'(TIMEOUT_CYCLES);
                    end
                end
                S_ARMED: begin
                    if (one_hot) begin
                        cand_d  = btn_s_q;
                        deb_d   = DW'(STABLE_CYCLES - 1);
                        state_d = S_DEBOUNCE;
                    end else begin
                        mp_pulse = multi;
                        if (timer_q == TW'(1)) begin
                            state_d  = S_IDLE;
                            to_pulse = 1'b1;
                        end else begin
                            timer_d = timer_q - TW'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    // Timer is frozen here; a bounce resumes ARMED with
                    // the remaining time intact.
                    if (btn_s_q != cand_q) begin
                        state_d = S_ARMED;
                    end else if (deb_q == DW'(1)) begin
                        state_d = S_CAST;
                    end else begin
                        deb_d = deb_q - DW'(1);
                    end
                end
                S_CAST: begin
                    state_d = S_BEEP;
                    bcnt_d  = BW'(BEEP_CYCLES);
                end
                S_BEEP: begin
                    if (bcnt_q == BW'(1)) begin
                        state_d = S_RELEASE;
                    end else begin
                        bcnt_d = bcnt_q - BW'(1);
                    end
                end
                S_RELEASE: begin
                    // A held button must be let go before the next ballot.
                    if (btn_s_q == 5'd0) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 5'd0;
            btn_s_q <= 5'd0;
            state_q <= S_IDLE;
            cand_q  <= 5'd0;
            timer_q <= '0;
            deb_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            sync1_q <= btn;
            btn_s_q <= sync1_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            timer_q <= timer_d;
            deb_q   <= deb_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Outputs are decoded from the next state so the registered values
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vo_en_q      <= 1'b0;
            vo_switch_q  <= 5'd0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            beep_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            multi_q      <= 1'b0;
            cast_count_q <= 8'd0;
        end else begin
            vo_en_q     <= poll_open;
            vo_switch_q <= (state_d == S_CAST) ? cand_d : 5'd0;
            ready_q     <= (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
            busy_q      <= (state_d != S_IDLE);
            beep_q      <= (state_d == S_BEEP);
            timed_out_q <= to_pulse;
            multi_q     <= mp_pulse;
            if ((state_d == S_CAST) && (cast_count_q != 8'hFF)) begin
                cast_count_q <= cast_count_q + 8'd1;
            end
        end
    end

    assign vo_en       = vo_en_q;
    assign vo_switch   = vo_switch_q;
    assign ready_led   = ready_q;
    assign busy        = busy_q;
    assign beep        = beep_q;
    assign timed_out   = timed_out_q;
    assign multi_press = multi_q;
    assign cast_count  = cast_count_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// tb_evm_ballot_unit: directed bench for evm_ballot_unit at default
// parameters; inputs change and outputs are sampled on the falling edge.
module tb_evm_ballot_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       poll_open = 1'b0;
    logic       ballot_issue = 1'b0;
    logic [4:0] btn = 5'd0;
    logic       vo_en;
    logic [4:0] vo_switch;
    logic       ready_led;
    logic       busy;
    logic       beep;
    logic       timed_out;
    logic       multi_press;
    logic [7:0] cast_count;

    int vectors = 0;
    int miscompares = 0;
    int n_vs, n_beep, n_mp, n_to, n_rdy;
    int pre_vs;

    evm_ballot_unit dut (
        .clk          (clk),
        .rst          (rst),
        .poll_open    (poll_open),
        .ballot_issue (ballot_issue),
        .btn          (btn),
        .vo_en        (vo_en),
        .vo_switch    (vo_switch),
        .ready_led    (ready_led),
        .busy         (busy),
        .beep         (beep),
        .timed_out    (timed_out),
        .multi_press  (multi_press),
        .cast_count   (cast_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        n_vs = 0; n_beep = 0; n_mp = 0; n_to = 0; n_rdy = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (vo_switch != 5'd0) n_vs++;
            if (beep) n_beep++;
            if (multi_press) n_mp++;
            if (timed_out) n_to++;
            if (ready_led) n_rdy++;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        chk("idle", 32'(busy), 0);
    endtask

    task automatic ballot(input logic [4:0] v);
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        btn = v;
        run(5);
        btn = 5'd0;
        wait_idle();
    endtask

    initial begin
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_vo_en", 32'(vo_en), 0);
        chk("rst_vo_switch", 32'(vo_switch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(cast_count), 0);
        rst = 1'b1;
        tick();

        // Single vote
        poll_open = 1'b1;
        ballot_issue = 1'b1;
        tick();
        chk("t1_ready", 32'(ready_led), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_vo_en", 32'(vo_en), 1);
        ballot_issue = 1'b0;
        btn = 5'b00100;
        run(4);
        chk("t1_early_vs", 32'(n_vs), 0);
        tick();
        chk("t1_cast", 32'(vo_switch), 'h04);
        chk("t1_count", 32'(cast_count), 1);
        chk("t1_vo_en_cast", 32'(vo_en), 1);
        chk("t1_beep_cast", 32'(beep), 0);
        run(5);
        chk("t1_beep_len", 32'(n_beep), 4);
        chk("t1_one_cast", 32'(n_vs), 0);
        chk("t1_release_busy", 32'(busy), 1);
        btn = 5'd0;
        wait_idle();

        // Bounce
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        pre_vs = 0;
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0) ? 5'b00001 : 5'b00000;
            tick();
            if (vo_switch != 5'd0) pre_vs++;
        end
        btn = 5'b00001;
        run(4);
        chk("t2_no_early", 32'(pre_vs + n_vs), 0);
        tick();
        chk("t2_cast", 32'(vo_switch), 'h01);
        chk("t2_count", 32'(cast_count), 2);
        run(5);
        chk("t2_one_cast", 32'(n_vs), 0);
        btn = 5'd0;
        wait_idle();

        // Multi-press and timeout
        btn = 5'b00011;
        run(3);
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        chk("t3_ready", 32'(ready_led), 1);
        chk("t3_mp_first", 32'(multi_press), 0);
        run(15);
        chk("t3_mp_count", 32'(n_mp), 15);
        chk("t3_no_to", 32'(n_to), 0);
        chk("t3_no_cast", 32'(n_vs), 0);
        chk("t3_busy", 32'(busy), 1);
        tick();
        chk("t3_timed_out", 32'(timed_out), 1);
        chk("t3_mp_last", 32'(multi_press), 1);
        chk("t3_idle", 32'(busy), 0);
        tick();
        chk("t3_to_pulse", 32'(timed_out), 0);
        chk("t3_mp_off", 32'(multi_press), 0);
        chk("t3_count", 32'(cast_count), 2);
        btn = 5'd0;
        run(3);

        // Held button across ballots
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        btn = 5'b10000;
        run(4);
        tick();
        chk("t4_cast", 32'(vo_switch), 'h10);
        chk("t4_count", 32'(cast_count), 3);
        run(5);
        chk("t4_beep_len", 32'(n_beep), 4);
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        chk("t4_ignored_ready", 32'(ready_led), 0);
        chk("t4_release_busy", 32'(busy), 1);
        run(10);
        chk("t4_no_recast", 32'(n_vs), 0);
        chk("t4_no_ready", 32'(n_rdy), 0);
        btn = 5'd0;
        wait_idle();
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        chk("t4_rearm", 32'(ready_led), 1);
        btn = 5'b00010;
        run(4);
        tick();
        chk("t4_cast2", 32'(vo_switch), 'h02);
        chk("t4_count2", 32'(cast_count), 4);
        btn = 5'd0;
        wait_idle();

        // Poll closed during DEBOUNCE
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        btn = 5'b01000;
        run(3);
        chk("t5_debounce", 32'(ready_led), 1);
        chk("t5_vo_en_hi", 32'(vo_en), 1);
        poll_open = 1'b0;
        tick();
        chk("t5_idle", 32'(busy), 0);
        chk("t5_ready", 32'(ready_led), 0);
        chk("t5_vs", 32'(vo_switch), 0);
        chk("t5_vo_en_lo", 32'(vo_en), 0);
        chk("t5_to", 32'(timed_out), 0);
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        chk("t5_closed_issue", 32'(busy), 0);
        run(20);
        chk("t5_no_cast", 32'(n_vs), 0);
        chk("t5_no_to", 32'(n_to), 0);
        chk("t5_no_ready", 32'(n_rdy), 0);
        chk("t5_count", 32'(cast_count), 4);
        btn = 5'd0;
        poll_open = 1'b1;
        run(3);

        // Saturation
        for (int i = 0; i < 251; i++) begin
            ballot(5'b00001 << (i % 5));
        end
        chk("t6_count_255", 32'(cast_count), 255);
        ballot(5'b00100);
        chk("t6_saturate", 32'(cast_count), 255);

        // Reset mid-BEEP
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
        btn = 5'b00001;
        run(4);
        tick();
        chk("t6_last_cast", 32'(vo_switch), 'h01);
        tick();
        tick();
        chk("t6_beeping", 32'(beep), 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_beep", 32'(beep), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_vo_en", 32'(vo_en), 0);
        chk("t6_rst_vs", 32'(vo_switch), 0);
        chk("t6_rst_ready", 32'(ready_led), 0);
        chk("t6_rst_to", 32'(timed_out), 0);
        chk("t6_rst_mp", 32'(multi_press), 0);
        chk("t6_rst_count", 32'(cast_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/evm_ballot_unit.md
# evm_ballot_unit

Voter-side ballot unit that drives the vote-entry interface of the voting machine counter. It accepts one authorization per voter from the presiding-officer control, debounces the five raw candidate buttons (Party1–Party4, NOTA), and issues exactly one single-cycle one-hot vote code on `vo_switch` while `vo_en` holds the poll session open. It also provides the voter feedback LEDs and beep, timeout, and a multi-press flag.

## Interface
- `STABLE_CYCLES`, default 3: number of consecutive synchronized samples a one-hot press must hold before it is cast; minimum 2.
- `TIMEOUT_CYCLES`, default 16: number of ARMED cycles allowed with no accepted press before the ballot is forfeited; minimum 1.
- `BEEP_CYCLES`, default 4: length of the confirmation beep, in cycles; minimum 1.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `poll_open` in 1: poll session level from the control unit.
- `ballot_issue` in 1: single-cycle authorization for one vote.
- `btn` in 5: raw, asynchronous candidate buttons; bit0 = Party1 … bit4 = NOTA.
- `vo_en` out 1: poll-session enable to the counter.
- `vo_switch` out 5: one-hot vote code, nonzero for exactly one cycle per cast.
- `ready_led` out 1: the ballot is armed and the voter may press.
- `busy` out 1: the unit is not IDLE.
- `beep` out 1: confirmation tone.
- `timed_out` out 1: one-cycle pulse when the ballot is forfeited.
- `multi_press` out 1: pulse for each ARMED cycle in which more than one button is seen.
- `cast_count` out 8: ballots cast since reset; saturates at 255.

## Operation
- **Synchronizer:** `btn` passes through a 2-flop synchronizer to produce `btn_s`. All decisions use `btn_s`.
- **States:** IDLE, ARMED, DEBOUNCE, CAST, BEEP, RELEASE.
- **IDLE:**
  - `ballot_issue`=1 with `poll_open`=1 → ARMED, and the timer is loaded with TIMEOUT_CYCLES.
  - `ballot_issue` is ignored in every other state and whenever `poll_open`=0. There is no queuing.
- **ARMED:**
  - `btn_s` one-hot → capture `cand`=`btn_s`, load the debounce counter with STABLE_CYCLES−1, and go to DEBOUNCE.
  - Otherwise:
    - If `btn_s` has more than one bit set, pulse `multi_press`.
    - If timer==1, go to IDLE and pulse `timed_out`; else decrement the timer.
- **DEBOUNCE:**
  - If `btn_s`≠`cand`, return to ARMED. The timer keeps its value; it is frozen during DEBOUNCE.
  - Else if counter==1, go to CAST.
  - Else decrement the counter.
- **CAST (1 cycle):**
  - `vo_switch`=`cand`.
  - `cast_count` increments, saturating at 255.
  - Next state is BEEP with the beep counter loaded with BEEP_CYCLES.
- **BEEP:** `beep`=1. When the counter reaches 1, go to RELEASE.
- **RELEASE:** wait for `btn_s`==0, then go to IDLE. This stops a held button from being cast again under the next authorization.
- **Poll closed:** `poll_open`=0 in any state other than IDLE forces IDLE on the next edge and clears `cand`. No cast and no `timed_out` pulse occur. If the state is already CAST, that cast completes.
- **Output decodes:**
  - `ready_led` = ARMED or DEBOUNCE.
  - `busy` = state≠IDLE.
  - `vo_switch`=0 in every state except CAST.
- **Output registers:** all outputs are registered.
  - `vo_en` is `poll_open` delayed by one cycle.
  - Because CAST is only entered when `poll_open` was 1 on the previous edge, `vo_en`=1 in every CAST cycle.

## Timing
- **Reset:** every output, the state (IDLE), all counters, `cand`, and the synchronizer clear to 0 asynchronously.
- **Cast latency:** a raw press stable from edge t gives `btn_s` valid in cycle t+2. The one-hot `vo_switch` then appears in cycle t+2+STABLE_CYCLES (t+5 at the defaults).
- **After `ballot_issue`** at edge a: `ready_led` rises in cycle a+1. With no press, `timed_out` pulses in cycle a+1+TIMEOUT_CYCLES, which is also the first IDLE cycle.
- **Beep:** `beep` is high for exactly BEEP_CYCLES cycles, starting in the cycle after the `vo_switch` pulse.
- **Multiple presses:** a bounce or a second button seen during DEBOUNCE restarts the debounce. A press of several buttons at once is never cast.
- **Saturation:** `cast_count` at 255 holds at 255 on further casts.
- **Reset during any state** returns to IDLE with no output pulse.

## Test plan
- **Single vote:** `poll_open`=1, `ballot_issue` pulse, `btn`=00100 held 10 cycles → exactly one cycle of `vo_switch`=00100 (5 cycles after the press), `vo_en`=1, `cast_count`=1, `beep` high for 4 cycles, return to IDLE after release.
- **Bounce:** `btn` toggles 00001/00000 every cycle for 6 cycles, then holds 00001 → exactly one cast of 00001, 5 cycles after the final stable press.
- **Multi-press and timeout:** `btn`=00011 held after `ballot_issue` → `multi_press` pulses each ARMED cycle, no cast, `timed_out` pulse 17 cycles after `ballot_issue`, `cast_count` unchanged.
- **Held button across ballots:** hold `btn`=10000 through a cast, then issue a second `ballot_issue` while still held → unit stays in RELEASE, ignores the issue, and produces no second cast until the button is released and a new issue arrives.
- **Poll closed:** `poll_open` dropped during DEBOUNCE → IDLE next cycle, `vo_switch` stays 0, `vo_en` falls one cycle later, `timed_out` stays 0.
- **Saturation and reset:** 256 ballots → `cast_count`=255. Then `rst` low mid-BEEP → all outputs 0 immediately.
